// File: rtl/exmem_pkg.sv
// Shared encodings for the execute/memory stage.
// ALU opcodes, access sizes and the memory FSM states.
package exmem_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/exmem_alu.sv
// Combinational integer ALU for the execute/memory stage.
// Shifts use the low log2(XLEN) bits of operand B.
module alu_core
    import exmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  y,
    output logic             zero
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt;

    assign shamt = b[SHW-1:0];
    assign lt    = $signed(a) < $signed(b);

    // Operation select
    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SLT: y = {{(XLEN-1){1'b0}}, lt};
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/exmem_stage.sv
// Execute/memory pipeline stage: ALU/FPU select, lane-aligned
// loads/stores over req/ack with timeout, registered result.
module exmem_stage
    import exmem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [XLEN-1:0]   imm,
    input  logic              alu_src,
    input  logic [2:0]        alu_ctrl,
    input  logic              d_src,
    input  logic [XLEN-1:0]   fpu_result,
    input  logic              mem_src,
    input  logic [XLEN-1:0]   fpu_store,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rd,
    input  logic              reg_write,
    output logic              zero,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [4:0]        out_rd,
    output logic              out_reg_write,
    output logic              out_misaligned,
    output logic              out_bus_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [OFFW-1:0]   off_q, off_d;
    size_e             sz_q, sz_d;
    logic              uns_q, uns_d;
    logic [4:0]        rd_q, rd_d;
    logic              rw_q, rw_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rw_q, out_rw_d;
    logic              out_mis_q, out_mis_d;
    logic              out_berr_q, out_berr_d;

    logic              is_mem;
    logic              accept;
    logic              tmo;
    alu_op_e           op;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   alu_y;
    logic [XLEN-1:0]   nm_res;
    size_e             sz_in;
    logic [OFFW-1:0]   off_in;
    logic [AW-1:0]     ea_aw;
    logic              mis;
    logic [NB-1:0]     sz_mask;
    logic [XLEN-1:0]   st_data;
    logic [XLEN-1:0]   ld_sh;
    logic [XLEN-1:0]   ld_val;
    logic              ld_sign;
    int                ld_bits;

    // Memory ops always use the adder to form the effective address
    assign is_mem = mem_read | mem_write;
    assign op     = is_mem ? ALU_ADD : alu_op_e'(alu_ctrl);
    assign opb    = alu_src ? imm : src_b;

    alu_core #(
        .XLEN (XLEN)
    ) u_alu (
        .op   (op),
        .a    (src_a),
        .b    (opb),
        .y    (alu_y),
        .zero (zero)
    );

    assign nm_res  = d_src ? fpu_result : alu_y;
    assign sz_in   = size_e'(funct3[1:0]);
    assign off_in  = alu_y[OFFW-1:0];
    assign ea_aw   = AW'(alu_y);
    assign st_data = mem_src ? fpu_store : src_b;

    assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign tmo      = (TIMEOUT != 0) && (cnt_q == TLAST);

    // Alignment check and byte-enable mask for the incoming access
    always_comb begin
        mis     = 1'b0;
        sz_mask = '1;
        unique case (sz_in)
            SZ_B: begin
                mis     = 1'b0;
                sz_mask = NB'(1);
            end
            SZ_H: begin
                mis     = alu_y[0];
                sz_mask = NB'(3);
            end
            SZ_W: begin
                mis     = |alu_y[1:0];
                sz_mask = NB'(15);
            end
            default: begin
                mis     = |off_in;
                sz_mask = '1;
            end
        endcase
    end

    // Pull the addressed lane down to bit 0 and extend it
    always_comb begin
        ld_sh   = mem_rdata >> {off_q, 3'b000};
        ld_val  = ld_sh;
        ld_sign = ld_sh[XLEN-1];
        ld_bits = XLEN;
        unique case (sz_q)
            SZ_B: begin
                ld_sign = ld_sh[7];
                ld_bits = 8;
            end
            SZ_H: begin
                ld_sign = ld_sh[15];
                ld_bits = 16;
            end
            SZ_W: begin
                ld_sign = ld_sh[31];
                ld_bits = 32;
            end
            default: begin
                ld_sign = ld_sh[XLEN-1];
                ld_bits = XLEN;
            end
        endcase
        for (int i = 0; i < XLEN; i++) begin
            if (i >= ld_bits) begin
                ld_val[i] = !uns_q && ld_sign;
            end
        end
    end

    // FSM next state, bus request and result register updates
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        off_d        = off_q;
        sz_d         = sz_q;
        uns_d        = uns_q;
        rd_d         = rd_q;
        rw_d         = rw_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_rw_d     = out_rw_q;
        out_mis_d    = out_mis_q;
        out_berr_d   = out_berr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !is_mem) begin
                    out_valid_d  = 1'b1;
                    out_result_d = nm_res;
                    out_rd_d     = rd;
                    out_rw_d     = reg_write;
                    out_mis_d    = 1'b0;
                    out_berr_d   = 1'b0;
                end else if (accept && mis) begin
                    out_valid_d  = 1'b1;
                    out_result_d = '0;
                    out_rd_d     = rd;
                    out_rw_d     = 1'b0;
                    out_mis_d    = 1'b1;
                    out_berr_d   = 1'b0;
                end else if (accept) begin
                    state_d     = ST_REQ;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_write;
                    mem_addr_d  = ea_aw & ~AW'(NB - 1);
                    mem_be_d    = sz_mask << off_in;
                    mem_wdata_d = st_data << {off_in, 3'b000};
                    off_d       = off_in;
                    sz_d        = sz_in;
                    uns_d       = funct3[2];
                    rd_d        = rd;
                    rw_d        = reg_write;
                end
            end
            ST_REQ: begin
                if (mem_ack || tmo) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '0;
                    out_valid_d  = 1'b1;
                    out_rd_d     = rd_q;
                    out_mis_d    = 1'b0;
                    out_berr_d   = !mem_ack;
                    out_result_d = '0;
                    out_rw_d     = 1'b0;
                    if (mem_ack && !mem_we_q) begin
                        out_result_d = ld_val;
                        out_rw_d     = rw_q;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            off_q        <= '0;
            sz_q         <= SZ_B;
            uns_q        <= 1'b0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_rw_q     <= 1'b0;
            out_mis_q    <= 1'b0;
            out_berr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            off_q        <= off_d;
            sz_q         <= sz_d;
            uns_q        <= uns_d;
            rd_q         <= rd_d;
            rw_q         <= rw_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_rw_q     <= out_rw_d;
            out_mis_q    <= out_mis_d;
            out_berr_q   <= out_berr_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_rd         = out_rd_q;
    assign out_reg_write  = out_rw_q;
    assign out_misaligned = out_mis_q;
    assign out_bus_err    = out_berr_q;

endmodule

// File: tb/tb_exmem_stage.sv
// Bench for exmem_stage: byte-level memory model, transaction queue
// of expected results, directed literal cases then random traffic.
module tb_exmem_stage;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src_a, src_b, imm;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        d_src;
    logic [31:0] fpu_result;
    logic        mem_src;
    logic [31:0] fpu_store;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        zero;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_misaligned, out_bus_err;

    exmem_stage #(
        .XLEN    (32),
        .AW      (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .src_a          (src_a),
        .src_b          (src_b),
        .imm            (imm),
        .alu_src        (alu_src),
        .alu_ctrl       (alu_ctrl),
        .d_src          (d_src),
        .fpu_result     (fpu_result),
        .mem_src        (mem_src),
        .fpu_store      (fpu_store),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .rd             (rd),
        .reg_write      (reg_write),
        .zero           (zero),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write),
        .out_misaligned (out_misaligned),
        .out_bus_err    (out_bus_err)
    );

    typedef struct {
        int          lat;
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          k;
        logic [31:0] ea;
        int          n;
        logic [31:0] sdata;
        logic [31:0] res;
        logic [4:0]  rd;
        bit          rw;
        bit          mis;
        bit          berr;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  refmem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          ridx = 0;
    int          next_k = -1;
    int          ord_mode = 1;
    bit          rnd_mode = 0;
    bit          drv_valid = 0;
    bit          accepted = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h req=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [7:0] d;
        d = a[7:0] ^ 8'h5C;
        if (refmem.exists(a)) d = refmem[a];
        return d;
    endfunction

    function automatic logic [31:0] alu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0] c);
        logic [4:0] s;
        s = b[4:0];
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return a << s;
            default: return a >> s;
        endcase
    endfunction

    function automatic logic [31:0] ld_model(input logic [31:0] ea,
                                             input int n, input bit uns);
        logic [31:0] v;
        v = '0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = rd_byte(ea + j);
        if (!uns && v[8*n-1])
            for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_expected();
        exp_t        e;
        logic [31:0] opb;
        int          lane;
        opb = alu_src ? imm : src_b;
        e = '{default: 0};
        e.rd = rd;
        e.lat = 1;
        if (!(mem_read || mem_write)) begin
            e.res = d_src ? fpu_result : alu_model(src_a, opb, alu_ctrl);
            e.rw = reg_write;
        end else begin
            e.ea = src_a + opb;
            e.n = 1 << funct3[1:0];
            if ((e.ea % e.n) != 0) begin
                e.mis = 1;
            end else begin
                e.req = 1;
                e.we = mem_write;
                e.addr = e.ea & ~32'd3;
                e.sdata = mem_src ? fpu_store : src_b;
                for (int j = 0; j < e.n; j++) begin
                    lane = (e.ea % 4) + j;
                    e.be[lane] = 1'b1;
                    e.wdata[8*lane +: 8] = e.sdata[8*j +: 8];
                end
                e.k = (next_k >= 0) ? next_k : $urandom_range(0, 5);
                if (e.k >= TMO) begin
                    e.lat = TMO + 1;
                    e.berr = 1;
                end else begin
                    e.lat = e.k + 2;
                    if (!e.we) begin
                        e.res = ld_model(e.ea, e.n, funct3[2]);
                        e.rw = reg_write;
                    end
                end
            end
        end
        q.push_back(e);
    endtask

    task automatic rand_instr();
        int t;
        t = $urandom_range(0, 3);
        in_valid = ($urandom_range(0, 3) != 0);
        src_b = $urandom;
        imm = $urandom;
        fpu_result = $urandom;
        fpu_store = $urandom;
        rd = 5'($urandom);
        reg_write = 1'($urandom);
        d_src = ($urandom_range(0, 4) == 0);
        mem_src = 1'($urandom);
        alu_ctrl = 3'($urandom);
        funct3 = {1'($urandom), 2'($urandom_range(0, 2))};
        if (t < 2) begin
            mem_read = 1'b0;
            mem_write = 1'b0;
            src_a = $urandom;
            alu_src = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                src_a = $urandom_range(0, 40);
                src_b = $urandom_range(0, 40);
            end
            if ($urandom_range(0, 5) == 0) begin
                src_b = src_a;
                alu_src = 1'b0;
            end
        end else begin
            src_a = $urandom_range(0, 255);
            imm = $urandom_range(0, 31);
            alu_src = 1'b1;
            mem_write = (t == 3);
            mem_read = (t == 2) ? 1'b1 : 1'($urandom);
        end
    endtask

    task automatic cycle();
        bit          exp_v;
        bit          exp_req;
        bit          exp_ir;
        logic [31:0] lm;
        logic [31:0] w;
        @(negedge clk);
        accepted = 0;
        if (q.size() > 0 && q[0].lat > 0) q[0].lat = q[0].lat - 1;
        exp_v = (q.size() > 0) && (q[0].lat == 0);
        chk("out_valid", out_valid, exp_v);
        if (out_valid && exp_v) begin
            chk("out_rd", out_rd, q[0].rd);
            chk("out_reg_write", out_reg_write, q[0].rw);
            chk("out_misaligned", out_misaligned, q[0].mis);
            chk("out_bus_err", out_bus_err, q[0].berr);
            if (!q[0].berr) chk("out_result", out_result, q[0].res);
        end
        exp_req = (q.size() > 0) && q[0].req && (q[0].lat > 0);
        chk("mem_req", mem_req, exp_req);
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        if (mem_req && exp_req) begin
            lm = '0;
            for (int l = 0; l < 4; l++) if (q[0].be[l]) lm[8*l +: 8] = 8'hFF;
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_be", mem_be, q[0].be);
            chk("mem_we", mem_we, q[0].we);
            chk("mem_wdata", mem_wdata & lm, q[0].wdata);
            if (ridx == q[0].k) begin
                mem_ack = 1'b1;
                for (int i = 0; i < 4; i++) w[8*i +: 8] = rd_byte(q[0].addr + i);
                mem_rdata = w;
                if (q[0].we)
                    for (int j = 0; j < q[0].n; j++)
                        refmem[q[0].ea + j] = q[0].sdata[8*j +: 8];
            end
            ridx++;
        end else begin
            ridx = 0;
        end
        case (ord_mode)
            1: out_ready = 1'b1;
            2: out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (exp_v && out_ready) void'(q.pop_front());
        if (rnd_mode) rand_instr();
        else in_valid = drv_valid;
        #1;
        if (q.size() == 0) exp_ir = 1'b1;
        else if (q[0].lat > 0) exp_ir = 1'b0;
        else exp_ir = out_ready;
        chk("in_ready", in_ready, exp_ir);
        if (!(mem_read || mem_write))
            chk("zero", zero, alu_model(src_a, alu_src ? imm : src_b, alu_ctrl) == 0);
        if (in_valid && in_ready) begin
            push_expected();
            accepted = 1;
            if (!rnd_mode) drv_valid = 0;
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic asrc,
                          input logic [2:0] ctrl, input logic mr,
                          input logic mw, input logic [2:0] f3);
        src_a = a;
        src_b = b;
        imm = im;
        alu_src = asrc;
        alu_ctrl = ctrl;
        mem_read = mr;
        mem_write = mw;
        funct3 = f3;
        d_src = 1'b0;
        mem_src = 1'b0;
        fpu_result = 32'hDEAD_0001;
        fpu_store = 32'hDEAD_0002;
        rd = 5'd7;
        reg_write = 1'b1;
    endtask

    task automatic issue();
        drv_valid = 1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) chk("issue_timeout", 0, 1);
        drv_valid = 0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (out_valid) break;
        end
        if (!out_valid) chk("wait_out_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            cycle();
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        out_ready = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        in_valid = 1'b0;
        set_op(0, 0, 0, 0, 3'd0, 0, 0, 3'd0);
        refmem[32'h100] = 8'h00;
        refmem[32'h101] = 8'h00;
        refmem[32'h102] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_reg_write", out_reg_write, 0);
        chk("rst_out_misaligned", out_misaligned, 0);
        chk("rst_out_bus_err", out_bus_err, 0);
        chk("rst_in_ready", in_ready, 1);

        ord_mode = 1;
        set_op(32'd5, 32'd0, 32'hFFFF_FFF9, 1, 3'd0, 0, 0, 3'd0);
        issue();
        cycle();
        chk("add_valid", out_valid, 1);
        chk("add_result", out_result, 32'hFFFF_FFFE);

        set_op(32'h1234, 32'h1234, 32'd0, 0, 3'd1, 0, 0, 3'd0);
        issue();
        chk("sub_zero", zero, 1);
        drain();

        set_op(32'h100, 32'hA5, 32'd3, 1, 3'd0, 0, 1, 3'b000);
        next_k = 2;
        issue();
        cycle();
        chk("sb_req", mem_req, 1);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata_hi", mem_wdata[31:24], 8'hA5);
        chk("sb_addr", mem_addr, 32'h100);
        drain();

        set_op(32'h100, 32'd0, 32'd3, 1, 3'd0, 1, 0, 3'b000);
        issue();
        wait_out();
        chk("lb_result", out_result, 32'hFFFF_FFA5);
        drain();
        set_op(32'h100, 32'd0, 32'd3, 1, 3'd0, 1, 0, 3'b100);
        issue();
        wait_out();
        chk("lbu_result", out_result, 32'h0000_00A5);
        drain();

        set_op(32'h100, 32'd0, 32'd2, 1, 3'd0, 1, 0, 3'b010);
        issue();
        cycle();
        chk("mis_req", mem_req, 0);
        chk("mis_flag", out_misaligned, 1);
        chk("mis_rw", out_reg_write, 0);
        drain();

        set_op(32'h100, 32'd0, 32'd0, 1, 3'd0, 1, 0, 3'b010);
        next_k = TMO - 1;
        ord_mode = 2;
        issue();
        repeat (TMO) begin
            cycle();
            chk("wait_addr", mem_addr, 32'h100);
            chk("wait_in_ready", in_ready, 0);
        end
        repeat (3) begin
            cycle();
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, 32'hA500_0000);
        end
        ord_mode = 1;
        drain();

        set_op(32'h104, 32'd0, 32'd0, 1, 3'd0, 1, 0, 3'b010);
        next_k = 99;
        issue();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (mem_req) n++;
            if (out_valid) break;
        end
        chk("tmo_req_cycles", n, TMO);
        chk("tmo_bus_err", out_bus_err, 1);
        chk("tmo_rw", out_reg_write, 0);
        drain();
        set_op(32'd1, 32'd2, 32'd0, 0, 3'd0, 0, 0, 3'd0);
        issue();
        cycle();
        chk("post_tmo_result", out_result, 32'd3);
        chk("post_tmo_berr", out_bus_err, 0);
        chk("post_tmo_mis", out_misaligned, 0);
        drain();

        set_op(32'h100, 32'd0, 32'd0, 1, 3'd0, 1, 0, 3'b010);
        issue();
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", mem_req, 0);
        chk("midrst_valid", out_valid, 0);
        q.delete();
        ridx = 0;
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_k = 1;
        set_op(32'h100, 32'd0, 32'd3, 1, 3'd0, 1, 0, 3'b100);
        issue();
        wait_out();
        chk("post_rst_load", out_result, 32'h0000_00A5);
        drain();

        next_k = -1;
        ord_mode = 0;
        rnd_mode = 1;
        repeat (3000) cycle();
        rnd_mode = 0;
        drv_valid = 0;
        ord_mode = 1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
